// File: rtl/alif_multichan_neuron.sv
// alif_multichan_neuron
//   Adaptive leaky integrate-and-fire neuron with N_CH weighted input channels.
//   A sample is accepted with a valid/ready handshake. Its channel contributions
//   are then accumulated serially, one channel per cycle, through a single
//   multiplier. A one-cycle UPDATE step integrates the sum into the membrane,
//   applies periodic leak, clamps the result, fires against an adaptive
//   threshold and, after a spike, holds off new samples for a programmable
//   refractory period.
//
//   Optional feature macro: ALIF_SPIKE_COUNT_EN
//     When it is defined, the block adds a saturating 16-bit spike_count output.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              global run; low freezes all state and masks pulses
//   params_ready        configuration valid; gates sample acceptance only
//   in_valid/in_ready   input handshake for chan_in/weights
//   chan_in             packed unsigned inputs, channel k at [k*IN_BITS +: IN_BITS]
//   weights             packed signed weights, channel k at [k*W_BITS +: W_BITS]
//   leak_rate           amount subtracted on a leak event
//   leak_cycles         accepted samples between leak events
//   threshold_min       base firing threshold
//   refrac_period       refractory length in enabled cycles (0 = none)
//   spike_out           spike pulse, qualified by out_valid
//   out_valid           one-cycle pulse marking a completed sample update
//   v_mem_out           current membrane potential
//   busy                high whenever the FSM is not idle
//   spike_count         (ALIF_SPIKE_COUNT_EN only) saturating spike counter
module alif_multichan_neuron #(
  parameter int N_CH    = 4,
  parameter int IN_BITS = 3,
  parameter int W_BITS  = 4,
  parameter int V_BITS  = 8,
  parameter int THR_UP  = 4,
  parameter int THR_DN  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     params_ready,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*IN_BITS-1:0]  chan_in,
  input  logic [N_CH*W_BITS-1:0]   weights,
  input  logic [V_BITS-1:0]        leak_rate,
  input  logic [3:0]               leak_cycles,
  input  logic [V_BITS-1:0]        threshold_min,
  input  logic [3:0]               refrac_period,
  output logic                     spike_out,
  output logic                     out_valid,
  output logic [V_BITS-1:0]        v_mem_out,
  output logic                     busy
`ifdef ALIF_SPIKE_COUNT_EN
  ,
  output logic [15:0]              spike_count
`endif
);

  localparam int CLOG_N = (N_CH > 1) ? $clog2(N_CH) : 0;
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int P_W    = IN_BITS + W_BITS + 1;
  localparam int ACC_W  = IN_BITS + W_BITS + CLOG_N + 1;
  // Wide enough for v_mem + acc - leak_rate without wrapping.
  localparam int NV_W   = ((ACC_W > V_BITS) ? ACC_W : V_BITS) + 2;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [V_BITS:0]   UP_STEP  = (V_BITS+1)'(THR_UP);
  localparam logic [V_BITS-1:0] DN_STEP  = V_BITS'(THR_DN);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, REFRAC} state_t;

  // Clamp a signed intermediate membrane value into [0, 2^V_BITS-1].
  function automatic logic [V_BITS-1:0] clamp_v(input logic signed [NV_W-1:0] x);
    if (x[NV_W-1])
      return '0;
    else if (|x[NV_W-2:V_BITS])
      return '1;
    else
      return x[V_BITS-1:0];
  endfunction

  // Raise the threshold offset, saturating at the base threshold.
  function automatic logic [V_BITS-1:0] ofs_up(input logic [V_BITS-1:0] ofs,
                                               input logic [V_BITS-1:0] tmin);
    logic [V_BITS:0] s;
    s = {1'b0, ofs} + UP_STEP;
    if (s > {1'b0, tmin})
      return tmin;
    else
      return s[V_BITS-1:0];
  endfunction

  // Lower the threshold offset, saturating at zero.
  function automatic logic [V_BITS-1:0] ofs_down(input logic [V_BITS-1:0] ofs);
    if (ofs > DN_STEP)
      return ofs - DN_STEP;
    else
      return '0;
  endfunction

`ifdef ALIF_SPIKE_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    if (c == 16'hFFFF)
      return c;
    else
      return c + 16'd1;
  endfunction
`endif

  state_t                    state;
  logic [V_BITS-1:0]         v_mem;
  logic [V_BITS-1:0]         thr_ofs;
  logic [3:0]                leak_cnt;
  logic [3:0]                refr_cnt;
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          idx;
  logic [N_CH*IN_BITS-1:0]   chan_q;
  logic [N_CH*W_BITS-1:0]    weights_q;

  logic                      accept_ok;
  logic [IN_BITS-1:0]        cur_ch;
  logic signed [IN_BITS:0]   cur_ch_s;
  logic signed [W_BITS-1:0]  cur_w;
  logic signed [P_W-1:0]     prod;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic                      leak_event;
  logic signed [NV_W-1:0]    v_ext;
  logic signed [NV_W-1:0]    acc_ext;
  logic signed [NV_W-1:0]    leak_ext;
  logic signed [NV_W-1:0]    new_v_raw;
  logic [V_BITS-1:0]         new_v;
  logic [V_BITS:0]           thr_eff;
  logic                      fire;

  // ---- serial multiply-accumulate: one channel per ACCUM cycle ----
  assign cur_ch   = chan_q[idx*IN_BITS +: IN_BITS];
  assign cur_w    = weights_q[idx*W_BITS +: W_BITS];
  assign cur_ch_s = {1'b0, cur_ch};
  assign prod     = P_W'(cur_ch_s) * P_W'(cur_w);
  assign acc_nxt  = acc + ACC_W'(prod);

  // ---- membrane update, evaluated combinationally during UPDATE ----
  assign leak_event = (leak_cnt >= leak_cycles);
  assign v_ext      = NV_W'($signed({1'b0, v_mem}));
  assign acc_ext    = NV_W'(acc);
  assign leak_ext   = NV_W'($signed({1'b0, leak_rate}));
  assign new_v_raw  = v_ext + acc_ext - (leak_event ? leak_ext : '0);
  assign new_v      = clamp_v(new_v_raw);
  assign thr_eff    = {1'b0, threshold_min} + {1'b0, thr_ofs};
  assign fire       = ({1'b0, new_v} >= thr_eff);

  assign accept_ok  = (state == IDLE) && enable && params_ready;

  // The UPDATE state lasts one enabled cycle, so the pulses are decoded from
  // the registered state. This makes them visible in the same cycle that the
  // live configuration is applied.
  assign in_ready   = accept_ok && reset_n;
  assign out_valid  = (state == UPDATE) && enable;
  assign spike_out  = out_valid && fire;
  assign busy       = (state != IDLE);
  assign v_mem_out  = v_mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      v_mem     <= '0;
      thr_ofs   <= '0;
      leak_cnt  <= '0;
      refr_cnt  <= '0;
      acc       <= '0;
      idx       <= '0;
      chan_q    <= '0;
      weights_q <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (accept_ok && in_valid) begin
            chan_q    <= chan_in;
            weights_q <= weights;
            acc       <= '0;
            idx       <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_nxt;
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX)
            state <= UPDATE;
        end
        UPDATE: begin
          leak_cnt <= leak_event ? 4'd0 : leak_cnt + 4'd1;
          if (fire) begin
            v_mem   <= '0;
            thr_ofs <= ofs_up(thr_ofs, threshold_min);
            if (refrac_period != 4'd0) begin
              refr_cnt <= refrac_period;
              state    <= REFRAC;
            end else begin
              state <= IDLE;
            end
          end else begin
            v_mem <= new_v;
            if (leak_event)
              thr_ofs <= ofs_down(thr_ofs);
            state <= IDLE;
          end
        end
        REFRAC: begin
          // Leaving on the count of one makes REFRAC last exactly
          // refrac_period enabled cycles.
          refr_cnt <= (refr_cnt != 4'd0) ? refr_cnt - 4'd1 : 4'd0;
          if (refr_cnt <= 4'd1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALIF_SPIKE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      spike_count <= '0;
    else if (spike_out)
      spike_count <= sat_inc16(spike_count);
  end
`endif

endmodule

// File: tb/tb_alif_multichan_neuron.sv
module tb_alif_multichan_neuron;

  localparam int N_CH    = 4;
  localparam int IN_BITS = 3;
  localparam int W_BITS  = 4;
  localparam int V_BITS  = 8;
  localparam int THR_UP  = 4;
  localparam int THR_DN  = 1;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    enable;
  logic                    params_ready;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_CH*IN_BITS-1:0] chan_in;
  logic [N_CH*W_BITS-1:0]  weights;
  logic [V_BITS-1:0]       leak_rate;
  logic [3:0]              leak_cycles;
  logic [V_BITS-1:0]       threshold_min;
  logic [3:0]              refrac_period;
  logic                    spike_out;
  logic                    out_valid;
  logic [V_BITS-1:0]       v_mem_out;
  logic                    busy;
`ifdef ALIF_SPIKE_COUNT_EN
  logic [15:0]             spike_count;
`endif

  alif_multichan_neuron #(
    .N_CH(N_CH), .IN_BITS(IN_BITS), .W_BITS(W_BITS),
    .V_BITS(V_BITS), .THR_UP(THR_UP), .THR_DN(THR_DN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .params_ready(params_ready),
    .in_valid(in_valid), .in_ready(in_ready), .chan_in(chan_in), .weights(weights),
    .leak_rate(leak_rate), .leak_cycles(leak_cycles), .threshold_min(threshold_min),
    .refrac_period(refrac_period), .spike_out(spike_out), .out_valid(out_valid),
    .v_mem_out(v_mem_out), .busy(busy)
`ifdef ALIF_SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: membrane, threshold offset, leak counter, spikes.
  int m_v, m_ofs, m_lcnt, m_spikes;
  int s_ch[N_CH];
  int s_w[N_CH];
  int last_acc_cyc;
  bit chk_gap;

  function automatic int model_acc();
    int a = 0;
    for (int k = 0; k < N_CH; k++) a += s_ch[k] * s_w[k];
    return a;
  endfunction

  // Apply one completed sample to the model; returns whether it fires.
  function automatic bit model_step(input int a);
    int nv;
    bit leak;
    int thr;
    nv   = m_v + a;
    leak = (m_lcnt >= int'(leak_cycles));
    if (leak) begin
      nv -= int'(leak_rate);
      m_lcnt = 0;
    end else begin
      m_lcnt++;
    end
    if (nv < 0) nv = 0;
    if (nv > 255) nv = 255;
    thr = int'(threshold_min) + m_ofs;
    if (nv >= thr) begin
      m_v = 0;
      m_ofs = (m_ofs + THR_UP < int'(threshold_min)) ? m_ofs + THR_UP : int'(threshold_min);
      m_spikes++;
      return 1'b1;
    end
    m_v = nv;
    if (leak) m_ofs = (m_ofs > THR_DN) ? m_ofs - THR_DN : 0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_v = 0; m_ofs = 0; m_lcnt = 0; m_spikes = 0;
    last_acc_cyc = -1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic set_uniform(input int c, input int w);
    for (int k = 0; k < N_CH; k++) begin s_ch[k] = c; s_w[k] = w; end
  endtask

  // Send one sample and check its result. frz_at > 0 drops enable for five
  // cycles starting at that many cycles after acceptance; abort pulses reset
  // during accumulation instead.
  task automatic run_sample(input int frz_at, input bit abort);
    int g;
    int lat;
    bit got;
    bit exp_sp;
    int refr;
    for (int k = 0; k < N_CH; k++) begin
      chan_in[k*IN_BITS +: IN_BITS] = IN_BITS'(s_ch[k]);
      weights[k*W_BITS +: W_BITS]   = W_BITS'(s_w[k]);
    end
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    if (chk_gap && last_acc_cyc >= 0)
      check("accept_gap", 32'(cyc - last_acc_cyc), 32'(N_CH + 2));
    last_acc_cyc = cyc;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (out_valid) begin
        got = 1'b1;
        lat = c;
        break;
      end
      if (abort && c == 2) reset_n = 1'b0;
      if (abort && c == 3) reset_n = 1'b1;
      if (frz_at > 0 && c == frz_at) enable = 1'b0;
      if (frz_at > 0 && c == frz_at + 5) enable = 1'b1;
    end
    if (abort) begin
      model_reset();
      check("abort_no_ovalid", 32'(got), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_vmem", 32'(v_mem_out), 32'd0);
      return;
    end
    check("out_valid_seen", 32'(got), 32'd1);
    if (!got) return;
    check("latency", 32'(lat), 32'(N_CH + 1 + ((frz_at > 0) ? 5 : 0)));
    exp_sp = model_step(model_acc());
    check("spike", 32'(spike_out), 32'(exp_sp));
    @(negedge clk);
    check("out_valid_pulse", 32'(out_valid), 32'd0);
    check("v_mem", 32'(v_mem_out), 32'(m_v));
`ifdef ALIF_SPIKE_COUNT_EN
    check("spike_count", 32'(spike_count), 32'(m_spikes));
`endif
    refr = exp_sp ? int'(refrac_period) : 0;
    for (int r = 0; r < refr; r++) begin
      if (r > 0) @(negedge clk);
      check("refrac_ready_low", 32'(in_ready), 32'd0);
    end
    if (refr > 0) @(negedge clk);
    check("ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int exp3[6] = '{2, 4, 3, 5, 7, 6};

  initial begin
    reset_n = 1'b0; enable = 1'b1; params_ready = 1'b1; in_valid = 1'b0;
    chan_in = '0; weights = '0; leak_rate = 8'd1; leak_cycles = 4'd15;
    threshold_min = 8'd20; refrac_period = 4'd2; chk_gap = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_spike", 32'(spike_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vmem", 32'(v_mem_out), 32'd0);
`ifdef ALIF_SPIKE_COUNT_EN
    check("rst_spike_count", 32'(spike_count), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    params_ready = 1'b0;
    @(negedge clk);
    check("params_gate", 32'(in_ready), 32'd0);
    params_ready = 1'b1;
    #1;
    check("params_open", 32'(in_ready), 32'd1);

    // All weights +2, inputs 3 -> acc 24, spike then 2-cycle refractory
    set_uniform(3, 2);
    run_sample(0, 1'b0);

    // Mixed-sign weights: acc -5 clamps at zero
    threshold_min = 8'd100;
    s_ch = '{7, 7, 2, 5};
    s_w  = '{3, -4, 1, 0};
    run_sample(0, 1'b0);

    // Leak every third sample
    do_reset();
    leak_rate = 8'd3; leak_cycles = 4'd2; threshold_min = 8'd200; refrac_period = 4'd0;
    s_ch = '{2, 0, 0, 0};
    s_w  = '{1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      run_sample(0, 1'b0);
      check("leak_seq", 32'(v_mem_out), 32'(exp3[i]));
    end

    // Repeated spiking: offset saturates at threshold_min, back-to-back rate
    do_reset();
    leak_rate = 8'd0; leak_cycles = 4'd15; threshold_min = 8'd10; refrac_period = 4'd0;
    chk_gap = 1'b1;
    set_uniform(3, 2);
    for (int i = 0; i < 4; i++) run_sample(0, 1'b0);
    s_ch = '{3, 3, 3, 1};
    s_w  = '{2, 2, 2, 1};
    run_sample(0, 1'b0);                // 19 < threshold 20
    check("sat_no_spike_v", 32'(v_mem_out), 32'd19);
    s_ch = '{1, 0, 0, 0};
    s_w  = '{1, 0, 0, 0};
    run_sample(0, 1'b0);                // 20 reaches threshold 20
    check("sat_spike_v", 32'(v_mem_out), 32'd0);
    chk_gap = 1'b0;

    // Enable low for 5 cycles mid-accumulation
    do_reset();
    threshold_min = 8'd20; leak_rate = 8'd1; refrac_period = 4'd0;
    set_uniform(3, 2);
    run_sample(2, 1'b0);
    s_ch = '{1, 2, 3, 4};
    s_w  = '{-3, 2, -1, 1};
    run_sample(3, 1'b0);

    // Reset mid-accumulation after a spike raised the offset
    do_reset();
    set_uniform(3, 2);
    run_sample(0, 1'b0);
    run_sample(0, 1'b1);
    s_ch = '{3, 3, 3, 2};
    s_w  = '{2, 2, 2, 2};               // 22: fires only if the offset was cleared
    run_sample(0, 1'b0);
    check("post_abort_spike_v", 32'(v_mem_out), 32'd0);

    // Randomized samples and configurations
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < N_CH; k++) begin
        s_ch[k] = int'($urandom_range(0, 7));
        s_w[k]  = int'($urandom_range(0, 15)) - 8;
      end
      threshold_min = 8'($urandom_range(15, 150));
      leak_rate     = 8'($urandom_range(0, 7));
      leak_cycles   = 4'($urandom_range(0, 15));
      refrac_period = 4'($urandom_range(0, 3));
      run_sample(((i % 9) == 4) ? 2 : 0, 1'b0);
    end

`ifdef ALIF_SPIKE_COUNT_EN
    do_reset();
    check("count_after_reset", 32'(spike_count), 32'd0);
    threshold_min = 8'd10; refrac_period = 4'd0;
    set_uniform(3, 2);
    for (int i = 0; i < 3; i++) run_sample(0, 1'b0);
    check("count_three", 32'(spike_count), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alif_multichan_neuron.md
Name: alif_multichan_neuron

Overview:
Parametrised successor to the dual-channel ALIF neuron. Supports N_CH input channels with signed per-channel weights, a programmable refractory period and a valid/ready input handshake. Input contributions are accumulated serially, one channel per cycle, through a single multiplier. The block sits between the spike/input loader and the output spike bus, and is instantiated per neuron in a layer.

Parameters:
N_CH, 4, number of input channels (>=1)
IN_BITS, 3, unsigned input magnitude width per channel
W_BITS, 4, signed two's-complement weight width per channel
V_BITS, 8, membrane and threshold width (unsigned)
THR_UP, 4, threshold-offset increase per spike
THR_DN, 1, threshold-offset decrease per silent leak event

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  global run; low freezes all state
params_ready  in  1  configuration valid; gates sample acceptance only
in_valid  in  1  sample present on chan_in
in_ready  out  1  block can accept a sample this cycle
chan_in  in  N_CH*IN_BITS  packed unsigned inputs; channel k at [k*IN_BITS +: IN_BITS]
weights  in  N_CH*W_BITS  packed signed weights, same packing
leak_rate  in  V_BITS  amount subtracted per leak event
leak_cycles  in  4  accepted samples between leak events
threshold_min  in  V_BITS  base threshold
refrac_period  in  4  refractory length in cycles (0 = none)
spike_out  out  1  one-cycle spike pulse, qualified by out_valid
out_valid  out  1  one-cycle pulse: sample update completed
v_mem_out  out  V_BITS  current membrane potential
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n low): state=IDLE, v_mem=0, thr_ofs=0, leak_cnt=0, refr_cnt=0, acc=0, idx=0. Outputs spike_out=0, out_valid=0, in_ready=0, busy=0, v_mem_out=0.
- Effective threshold = threshold_min + thr_ofs, computed at V_BITS+1 bits. thr_ofs never exceeds threshold_min, so the maximum threshold is 2*threshold_min.
- FSM states: IDLE, ACCUM, UPDATE, REFRAC. With enable=0: no transitions, no counter or register changes, in_ready=0, pulses forced to 0.
- IDLE: in_ready = enable & params_ready. On in_valid & in_ready, latch chan_in and weights, clear acc and idx, go to ACCUM.
- ACCUM: each cycle, acc += chan[idx] * weight[idx] (unsigned times signed, sign-extended), then idx++. Move to UPDATE after the N_CH-th channel.
  - acc width = IN_BITS + W_BITS + clog2(N_CH) + 1, signed; no overflow is possible.
- UPDATE (single cycle):
  - new_v = v_mem + acc, computed signed at V_BITS+2 bits or wider than acc.
  - leak_cnt increments. If leak_cnt >= leak_cycles, this is a leak event: new_v -= leak_rate and leak_cnt clears.
  - Clamp new_v to [0, 2^V_BITS-1].
  - Spike if new_v >= threshold: spike_out=1, v_mem=0, thr_ofs = min(thr_ofs+THR_UP, threshold_min). Go to REFRAC with refr_cnt=refrac_period if refrac_period != 0, else go to IDLE.
  - No spike: v_mem=new_v. On a leak event, thr_ofs = (thr_ofs > THR_DN) ? thr_ofs-THR_DN : 0. Go to IDLE.
  - out_valid=1 in this cycle in both cases.
- Latency: accept at cycle T gives out_valid/spike_out registered-high in cycle T+N_CH+1. Peak throughput is one sample per N_CH+2 cycles.
- REFRAC: in_ready=0, no leak, no integration. refr_cnt decrements once per enabled cycle; go to IDLE when it reaches 0, so REFRAC lasts exactly refrac_period enabled cycles.
- params_ready deasserting mid-sample does not abort the sample; config inputs are sampled live in UPDATE.
- v_mem_out = v_mem, always valid.
- Reset asserted mid-ACCUM discards the sample; no out_valid is produced.

Optional Feature:
ALIF_SPIKE_COUNT_EN
- Defined: adds output spike_count[15:0], which increments on each spike, saturates at 16'hFFFF and clears on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, threshold_min=20, weights all +2, chan_in all 3, leak_cycles=15, refrac=2 -> acc=24, spike on the first sample at cycle T+5, v_mem=0, thr_ofs=4, in_ready low for 2 cycles after UPDATE.
- Mixed-sign weights {+3,-4,+1,0}, chan {7,7,2,5}, threshold_min=100 -> acc=-5, v_mem clamps at 0, no spike, out_valid pulses.
- leak_rate=3, leak_cycles=2, acc=+2 per sample, threshold_min=200 -> leak on every 3rd accepted sample; v_mem sequence 2,4,3,5,7,6.
- Repeated spiking with threshold_min=10, refrac=0 -> thr_ofs saturates at 10 (threshold 20); back-to-back samples accepted every 6 cycles.
- enable low for 5 cycles mid-ACCUM -> idx/acc frozen, result identical to the uninterrupted case, delayed by 5 cycles; reset_n pulse mid-ACCUM -> no out_valid, all state returns to reset values.
- ALIF_SPIKE_COUNT_EN defined, 3 spikes -> spike_count=3; reset -> 0.
